// File: rtl/seq_restoring_divider_pkg.sv
// ----------------------------------------------------------------------------
// seq_restoring_divider_pkg
// Shared definitions for the sequential restoring divider:
//   divState_t     - FSM state encoding (IDLE / CALC / DONE)
//   WIDTH_DEFAULT  - default operand width
//   cntWidth()     - bit-counter width for a given operand width
//   CNT_W          - counter width at the default operand width
//   DIV0_QUOTIENT  - all-ones quotient returned on divide-by-zero
//                    (slice the low WIDTH bits)
// ----------------------------------------------------------------------------
package seq_restoring_divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } divState_t;

   localparam int WIDTH_DEFAULT = 8;

   // Counter must hold WIDTH-1; $clog2 is already >= 1 for the legal range 2..32.
   function automatic int cntWidth(input int w);
      return $clog2(w);
   endfunction

   localparam int CNT_W = cntWidth(WIDTH_DEFAULT);

   localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

endpackage

// File: rtl/seq_restoring_divider_div_sub_step.sv
// ----------------------------------------------------------------------------
// div_sub_step
// Combinational N-bit ripple borrow-chain subtractor used once per quotient
// bit by the divider.
// Ports:
//   minuend    [N-1:0] in  - shifted partial remainder
//   subtrahend [N-1:0] in  - zero-extended divisor
//   difference [N-1:0] out - minuend - subtrahend (mod 2^N)
//   borrowOut          out - 1 when minuend < subtrahend
// ----------------------------------------------------------------------------
module div_sub_step #(
   parameter int N = 9
) (
   input  logic [N-1:0] minuend,
   input  logic [N-1:0] subtrahend,
   output logic [N-1:0] difference,
   output logic         borrowOut
);

   logic [N:0] borrowChain;

   assign borrowChain[0] = 1'b0;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : gBit
         assign difference[gi]    = minuend[gi] ^ subtrahend[gi] ^ borrowChain[gi];
         // Borrow out when a<b, or a==b with a borrow coming in.
         assign borrowChain[gi+1] = (~minuend[gi] & subtrahend[gi])
                                  | (~(minuend[gi] ^ subtrahend[gi]) & borrowChain[gi]);
      end
   endgenerate

   assign borrowOut = borrowChain[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// ----------------------------------------------------------------------------
// seq_restoring_divider
// Multi-cycle restoring divider: one quotient bit per clock through a shared
// (WIDTH+1)-bit subtract step, sequenced by an IDLE/CALC/DONE FSM.
// Optional build macro: SEQ_DIVIDER_SIGNED_EN (two's complement operands;
// quotient negated when signs differ, remainder takes the dividend sign).
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   in_valid / in_ready     - operand handshake (accept when both high)
//   dividend, divisor       - operands, sampled only at the accept edge
//   out_valid / out_ready   - result handshake; result held until taken
//   quotient, remainder     - result
//   div_by_zero             - result came from a zero divisor
// ----------------------------------------------------------------------------
module seq_restoring_divider
   import seq_restoring_divider_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int cntW = cntWidth(WIDTH);
   localparam logic [cntW-1:0] lastBit = cntW'(WIDTH - 1);

   divState_t        state, stateNext;
   logic             accept;
   logic             divZero;

   logic [WIDTH:0]   remReg;     // partial remainder, one spare bit for the shift
   logic [WIDTH-1:0] shiftReg;   // dividend shifts out, quotient shifts in
   logic [WIDTH-1:0] divReg;
   logic [cntW-1:0]  count;
   logic             dbzReg;

   logic [WIDTH-1:0] dividendMag;
   logic [WIDTH-1:0] divisorMag;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic             borrow;

   // After a restore step the remainder is below the divisor, so its top bit
   // is always zero and is never fed back.
   logic             unusedRemMsb;
   assign unusedRemMsb = remReg[WIDTH];

   assign divZero = (divisor == '0);

`ifdef SEQ_DIVIDER_SIGNED_EN
   logic negQReg;
   logic negRReg;

   // Magnitude of MIN is MIN itself, which reads correctly as unsigned.
   assign dividendMag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
   assign divisorMag  = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         negQReg <= 1'b0;
         negRReg <= 1'b0;
      end else if (accept) begin
         // Divide-by-zero results are loaded raw, so no output negation.
         negQReg <= !divZero && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
         negRReg <= !divZero && dividend[WIDTH-1];
      end
   end

   assign quotient  = negQReg ? (~shiftReg + 1'b1) : shiftReg;
   assign remainder = negRReg ? (~remReg[WIDTH-1:0] + 1'b1) : remReg[WIDTH-1:0];
`else
   assign dividendMag = dividend;
   assign divisorMag  = divisor;
   assign quotient    = shiftReg;
   assign remainder   = remReg[WIDTH-1:0];
`endif

   assign div_by_zero = dbzReg;

   // Shift in the next dividend bit, then try to subtract the divisor.
   assign shifted = {remReg[WIDTH-1:0], shiftReg[WIDTH-1]};

   div_sub_step #(
      .N(WIDTH + 1)
   ) uSubStep (
      .minuend    (shifted),
      .subtrahend ({1'b0, divReg}),
      .difference (trial),
      .borrowOut  (borrow)
   );

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept    = 1'b1;
               stateNext = divZero ? DONE : CALC;
            end
         end
         CALC: begin
            if (count == '0) begin
               stateNext = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remReg   <= '0;
         shiftReg <= '0;
         divReg   <= '0;
         count    <= '0;
         dbzReg   <= 1'b0;
      end else if (accept) begin
         divReg <= divisorMag;
         dbzReg <= divZero;
         count  <= lastBit;
         if (divZero) begin
            shiftReg <= DIV0_QUOTIENT[WIDTH-1:0];
            remReg   <= {1'b0, dividend};
         end else begin
            shiftReg <= dividendMag;
            remReg   <= '0;
         end
      end else if (state == CALC) begin
         // Restore (keep the shifted value) when the trial subtract borrowed.
         remReg   <= borrow ? shifted : trial;
         shiftReg <= {shiftReg[WIDTH-2:0], ~borrow};
         if (count != '0) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seq_restoring_divider.sv
module tb_seq_restoring_divider;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   // standalone subtract-step probe
   logic [W:0]   subA = '0;
   logic [W:0]   subB = '0;
   logic [W:0]   subDiff;
   logic         subBorrow;

   int testsRun = 0;
   int testsFailed = 0;

   always #5 clk = ~clk;

   seq_restoring_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   div_sub_step #(.N(W + 1)) subDut (
      .minuend    (subA),
      .subtrahend (subB),
      .difference (subDiff),
      .borrowOut  (subBorrow)
   );

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Behavioural reference: plain arithmetic on the operand values.
   function automatic void refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic dz);
      int sa;
      int sb;
      dz = (b == 0);
      if (dz) begin
         q = '1;
         r = a;
      end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
         sa = int'($signed(a));
         sb = int'($signed(b));
`else
         sa = int'(a);
         sb = int'(b);
`endif
         q = W'(sa / sb);
         r = W'(sa % sb);
      end
   endfunction

   // One full transaction: accept, latency, optional backpressure, release.
   task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] expQ, input logic [W-1:0] expR,
                        input logic expDz, input int hold, input bit busyPoke);
      int n;
      int guard;
      bit stable;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      checkVal("in_ready_before_accept", in_ready, 1'b1);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      dividend  = a;
      divisor   = b;
      @(posedge clk);
      #1;
      // Operands change after accept; busy pokes must be ignored.
      dividend = W'($urandom);
      divisor  = W'($urandom);
      in_valid = busyPoke;
      n = 1;
      @(negedge clk);
      while (!out_valid && n < 4 * W) begin
         @(negedge clk);
         n++;
      end
      checkVal("latency", n, (b == 0) ? 1 : W + 1);
      in_valid = 1'b0;
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (!out_valid || quotient !== expQ || remainder !== expR) stable = 1'b0;
      end
      checkVal("hold_stable", stable, 1'b1);
      checkVal("quotient", quotient, expQ);
      checkVal("remainder", remainder, expR);
      checkVal("div_by_zero", div_by_zero, expDz);
      checkVal("in_ready_in_done", in_ready, 1'b0);
      $display("[TB] op %0d / %0d -> q=%0d r=%0d dz=%0d latency=%0d hold=%0d",
               a, b, quotient, remainder, div_by_zero, n, hold);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkVal("out_valid_after_release", out_valid, 1'b0);
      checkVal("in_ready_after_release", in_ready, 1'b1);
   endtask

   task automatic runModelOp(input logic [W-1:0] a, input logic [W-1:0] b,
                             input int hold, input bit busyPoke);
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic dz;
      refModel(a, b, q, r, dz);
      runOp(a, b, q, r, dz, hold, busyPoke);
   endtask

   task automatic resetMidCalc();
      bit sawValid;
      @(negedge clk);
      in_valid = 1'b1;
      dividend = 8'd200;
      divisor  = 8'd7;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkVal("rst_mid_out_valid", out_valid, 1'b0);
      checkVal("rst_mid_in_ready", in_ready, 1'b1);
      checkVal("rst_mid_quotient", quotient, '0);
      checkVal("rst_mid_remainder", remainder, '0);
      checkVal("rst_mid_dbz", div_by_zero, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      sawValid = 1'b0;
      repeat (W + 4) begin
         @(negedge clk);
         if (out_valid) sawValid = 1'b1;
      end
      checkVal("rst_no_out_valid", sawValid, 1'b0);
      $display("[TB] reset during CALC of 200 / 7");
      runOp(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 0, 1'b0);
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      // Subtract step standalone.
      for (int i = 0; i < 16; i++) begin
         logic [W+1:0] full;
         subA = (W + 1)'($urandom);
         subB = {1'b0, W'($urandom)};
         #1;
         full = {1'b0, subA} - {1'b0, subB};
         checkVal("sub_step", {subBorrow, subDiff}, full);
      end

      // Reset values while held in reset.
      #2;
      checkVal("reset_in_ready", in_ready, 1'b1);
      checkVal("reset_out_valid", out_valid, 1'b0);
      checkVal("reset_quotient", quotient, '0);
      checkVal("reset_remainder", remainder, '0);
      checkVal("reset_dbz", div_by_zero, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

`ifdef SEQ_DIVIDER_SIGNED_EN
      runOp(8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 0, 1'b0);   // -100 / 7
      runOp(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 0, 1'b0);   // -128 / -1
      runOp(8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 0, 1'b0);
      runOp(8'd100, 8'd10, 8'd10, 8'd0, 1'b0, 20, 1'b0);
      runOp(8'd77, 8'd5, 8'd15, 8'd2, 1'b0, 0, 1'b1);
`else
      runOp(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 0, 1'b0);
      runOp(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 0, 1'b0);
      runOp(8'd3, 8'd200, 8'd0, 8'd3, 1'b0, 0, 1'b0);
      runOp(8'd0, 8'd9, 8'd0, 8'd0, 1'b0, 0, 1'b0);
      runOp(8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 0, 1'b0);
      runOp(8'd100, 8'd10, 8'd10, 8'd0, 1'b0, 20, 1'b0);
      runOp(8'd77, 8'd5, 8'd15, 8'd2, 1'b0, 0, 1'b1);
`endif

      resetMidCalc();

      // Randomized operations against the reference model.
      for (int i = 0; i < 40; i++) begin
         ra = W'($urandom);
         case ($urandom_range(0, 7))
            0:       rb = '0;
            1:       rb = 8'd1;
            2:       rb = W'($urandom_range(1, 15));
            default: rb = W'($urandom);
         endcase
         runModelOp(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
